// File: rtl/mem_access_pkg.sv
// Shared types and constants for the word access unit: FSM state encoding,
// default widths and the load/store access-kind codes.
package mem_access_pkg;

  localparam int ADDR_W = 16;
  localparam int BYTE_W = 8;
  localparam int WORD_W = 16;

  localparam logic ACC_LOAD  = 1'b0;
  localparam logic ACC_STORE = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/mem_word_access_unit.sv
// 16-bit word load/store over an 8-bit byte memory as two byte accesses (A, A+1).
// Build option: define BIG_ENDIAN_EN to make the byte at A the word's MSB.
module mem_word_access_unit #(
  parameter int ADDR_W = mem_access_pkg::ADDR_W,
  parameter int BYTE_W = mem_access_pkg::BYTE_W,
  parameter int WORD_W = mem_access_pkg::WORD_W
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Start,
  input  logic              Write,
  input  logic [ADDR_W-1:0] Address,
  input  logic [WORD_W-1:0] WData,
  input  logic [BYTE_W-1:0] MemDataIn,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [BYTE_W-1:0] MemDataOut,
  output logic              MemCS,
  output logic              MemWR,
  output logic [WORD_W-1:0] RData,
  output logic              Busy,
  output logic              Done
);
  import mem_access_pkg::*;

`ifdef BIG_ENDIAN_EN
  localparam bit BIG_ENDIAN = 1'b1;
`else
  localparam bit BIG_ENDIAN = 1'b0;
`endif

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [BYTE_W-1:0] mem_dout_q, mem_dout_d;
  logic [BYTE_W-1:0] second_byte_q, second_byte_d;
  logic              write_q, write_d;
  logic [WORD_W-1:0] rdata_q, rdata_d;
  logic [BYTE_W-1:0] wdata_lo;
  logic [BYTE_W-1:0] wdata_hi;
  logic              byte_cycle;

  assign wdata_lo = WData[BYTE_W-1:0];
  assign wdata_hi = WData[WORD_W-1:BYTE_W];

  // Only the byte for the HI cycle is kept; the LO byte goes straight to the data register.
  always_comb begin
    state_d       = state_q;
    mem_addr_d    = mem_addr_q;
    mem_dout_d    = mem_dout_q;
    second_byte_d = second_byte_q;
    write_d       = write_q;
    rdata_d       = rdata_q;
    case (state_q)
      IDLE: begin
        if (Start) begin
          state_d       = LO;
          mem_addr_d    = Address;
          write_d       = Write;
          mem_dout_d    = BIG_ENDIAN ? wdata_hi : wdata_lo;
          second_byte_d = BIG_ENDIAN ? wdata_lo : wdata_hi;
        end
      end
      LO: begin
        state_d    = HI;
        mem_addr_d = mem_addr_q + ADDR_W'(1);
        mem_dout_d = second_byte_q;
        if (write_q == ACC_LOAD) begin
          if (BIG_ENDIAN) rdata_d[WORD_W-1:BYTE_W] = MemDataIn;
          else            rdata_d[BYTE_W-1:0]      = MemDataIn;
        end
      end
      HI: begin
        state_d = DONE;
        if (write_q == ACC_LOAD) begin
          if (BIG_ENDIAN) rdata_d[BYTE_W-1:0]      = MemDataIn;
          else            rdata_d[WORD_W-1:BYTE_W] = MemDataIn;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q       <= IDLE;
      mem_addr_q    <= '0;
      mem_dout_q    <= '0;
      second_byte_q <= '0;
      write_q       <= ACC_LOAD;
      rdata_q       <= '0;
    end else begin
      state_q       <= state_d;
      mem_addr_q    <= mem_addr_d;
      mem_dout_q    <= mem_dout_d;
      second_byte_q <= second_byte_d;
      write_q       <= write_d;
      rdata_q       <= rdata_d;
    end
  end

  // Gating with Reset keeps the memory from taking a write on the edge that aborts a store.
  assign byte_cycle = (state_q == LO) || (state_q == HI);
  assign MemCS      = byte_cycle && !Reset;
  assign MemWR      = MemCS && (write_q == ACC_STORE);
  assign MemAddr    = mem_addr_q;
  assign MemDataOut = mem_dout_q;
  assign RData      = rdata_q;
  assign Busy       = (state_q != IDLE);
  assign Done       = (state_q == DONE);

endmodule

// File: tb/tb_mem_word_access_unit.sv
// Scoreboard bench for mem_word_access_unit: stimulus pushes expected byte accesses and
// completions into queues, a negedge monitor pops and compares them as the DUT shows them.
module tb_mem_word_access_unit;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        Start;
  logic        Write;
  logic [15:0] Address;
  logic [15:0] WData;
  logic [7:0]  MemDataIn;
  logic [15:0] MemAddr;
  logic [7:0]  MemDataOut;
  logic        MemCS;
  logic        MemWR;
  logic [15:0] RData;
  logic        Busy;
  logic        Done;

  logic [7:0]  mem [0:65535];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  logic [15:0] last_rdata;

  typedef struct {
    logic [15:0] addr;
    logic        wr;
    logic [7:0]  data;
  } access_t;

  typedef struct {
    int          cyc;
    logic [15:0] rdata;
  } done_t;

  access_t access_q[$];
  done_t   done_q[$];
  access_t exp_acc;
  done_t   exp_done;

  mem_word_access_unit dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .Start      (Start),
    .Write      (Write),
    .Address    (Address),
    .WData      (WData),
    .MemDataIn  (MemDataIn),
    .MemAddr    (MemAddr),
    .MemDataOut (MemDataOut),
    .MemCS      (MemCS),
    .MemWR      (MemWR),
    .RData      (RData),
    .Busy       (Busy),
    .Done       (Done)
  );

  // Free-running 10-unit clock.
  always #5 Clock = ~Clock;

  // Byte memory with an asynchronous read port.
  assign MemDataIn = mem[MemAddr];

  // Memory write port and a cycle counter used to time Done pulses.
  always @(posedge Clock) begin
    cyc <= cyc + 1;
    if (MemCS && MemWR) mem[MemAddr] <= MemDataOut;
  end

  // Word assembled from the bytes at A and A+1 in the selected byte order.
  function automatic logic [15:0] word_of(input logic [7:0] byte_a, input logic [7:0] byte_a1);
`ifdef BIG_ENDIAN_EN
    return {byte_a, byte_a1};
`else
    return {byte_a1, byte_a};
`endif
  endfunction

  // Byte of a store word that lands at A.
  function automatic logic [7:0] first_byte(input logic [15:0] w);
`ifdef BIG_ENDIAN_EN
    return w[15:8];
`else
    return w[7:0];
`endif
  endfunction

  // Byte of a store word that lands at A+1.
  function automatic logic [7:0] second_byte(input logic [15:0] w);
`ifdef BIG_ENDIAN_EN
    return w[7:0];
`else
    return w[15:8];
`endif
  endfunction

  // Single comparison point; every check goes through here.
  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual %0h expected %0h", name, actual, expected);
    end
  endtask

  // All outputs at their reset values.
  task automatic checkResetState(input string tag);
    checkOutput({tag, "_mem_addr"}, 32'(MemAddr), 32'h0);
    checkOutput({tag, "_mem_dout"}, 32'(MemDataOut), 32'h0);
    checkOutput({tag, "_mem_cs"}, 32'(MemCS), 32'h0);
    checkOutput({tag, "_mem_wr"}, 32'(MemWR), 32'h0);
    checkOutput({tag, "_rdata"}, 32'(RData), 32'h0);
    checkOutput({tag, "_busy"}, 32'(Busy), 32'h0);
    checkOutput({tag, "_done"}, 32'(Done), 32'h0);
  endtask

  // Issue one transaction, scramble the inputs after capture, and wait until the unit is idle.
  task automatic applyStimulus(input logic wr, input logic [15:0] addr, input logic [15:0] wdata,
                               input logic [15:0] exp_rdata, input logic chk_hold,
                               input logic [15:0] hold_val);
    @(negedge Clock);
    Start   = 1'b1;
    Write   = wr;
    Address = addr;
    WData   = wdata;
    @(posedge Clock);
    #1;
    Start   = 1'b0;
    Write   = ~wr;
    Address = ~addr;
    WData   = ~wdata;
    access_q.push_back('{addr, wr, first_byte(wdata)});
    access_q.push_back('{addr + 16'd1, wr, second_byte(wdata)});
    if (!wr) last_rdata = exp_rdata;
    done_q.push_back('{cyc + 2, last_rdata});
    if (chk_hold) checkOutput("rdata_hold_in_lo", 32'(RData), 32'(hold_val));
    repeat (3) @(posedge Clock);
  endtask

  // Monitor: every chip-select cycle and every Done pulse must match the head of its queue.
  always @(negedge Clock) begin
    if (MemCS) begin
      if (access_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_access: actual addr %0h expected no access", MemAddr);
      end else begin
        exp_acc = access_q.pop_front();
        checkOutput("mem_addr", 32'(MemAddr), 32'(exp_acc.addr));
        checkOutput("mem_wr", 32'(MemWR), 32'(exp_acc.wr));
        if (exp_acc.wr) checkOutput("mem_dout", 32'(MemDataOut), 32'(exp_acc.data));
      end
    end
    if (Done) begin
      if (done_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_done: actual 1 expected 0 at cycle %0d", cyc);
      end else begin
        exp_done = done_q.pop_front();
        checkOutput("done_cycle", 32'(cyc), 32'(exp_done.cyc));
        checkOutput("rdata", 32'(RData), 32'(exp_done.rdata));
        checkOutput("busy_in_done", 32'(Busy), 32'h1);
      end
    end
  end

  // Directed sequence: reset, load, store, back-to-back wrap load, held Start, mid-store reset.
  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h0040] = 8'h34;
    mem[16'h0041] = 8'h12;
    mem[16'hFFFF] = 8'hAA;
    mem[16'h0000] = 8'h55;
    mem[16'h0200] = 8'h78;
    mem[16'h0201] = 8'h56;
    Reset      = 1'b1;
    Start      = 1'b0;
    Write      = 1'b0;
    Address    = 16'h0;
    WData      = 16'h0;
    last_rdata = 16'h0;

    repeat (2) @(posedge Clock);
    #1;
    Reset = 1'b0;
    checkResetState("reset");

    applyStimulus(1'b0, 16'h0040, 16'h0000, word_of(8'h34, 8'h12), 1'b0, 16'h0);
    applyStimulus(1'b1, 16'h0100, 16'hBEEF, 16'h0000, 1'b0, 16'h0);
    checkOutput("store_byte_a", 32'(mem[16'h0100]), 32'(first_byte(16'hBEEF)));
    checkOutput("store_byte_a1", 32'(mem[16'h0101]), 32'(second_byte(16'hBEEF)));
    checkOutput("store_no_spill", 32'(mem[16'h0102]), 32'h0);

    applyStimulus(1'b0, 16'hFFFF, 16'h0000, word_of(8'hAA, 8'h55), 1'b1, word_of(8'h34, 8'h12));

    // Start held ten cycles: accepted only from IDLE, at edges k, k+4 and k+8.
    @(negedge Clock);
    Start   = 1'b1;
    Write   = 1'b0;
    Address = 16'h0200;
    @(posedge Clock);
    #1;
    last_rdata = word_of(8'h78, 8'h56);
    for (int t = 0; t < 3; t++) begin
      access_q.push_back('{16'h0200, 1'b0, 8'h00});
      access_q.push_back('{16'h0201, 1'b0, 8'h00});
      done_q.push_back('{cyc + 4 * t + 2, last_rdata});
    end
    repeat (9) @(posedge Clock);
    #1;
    Start = 1'b0;
    repeat (3) @(posedge Clock);

    // Reset during the HI cycle of a store: first byte written, second not, no Done.
    @(negedge Clock);
    Start   = 1'b1;
    Write   = 1'b1;
    Address = 16'h0300;
    WData   = 16'h1357;
    @(posedge Clock);
    #1;
    Start = 1'b0;
    access_q.push_back('{16'h0300, 1'b1, first_byte(16'h1357)});
    @(posedge Clock);
    #1;
    Reset = 1'b1;
    @(posedge Clock);
    #1;
    Reset      = 1'b0;
    last_rdata = 16'h0;
    checkResetState("abort");
    repeat (3) @(posedge Clock);
    checkOutput("abort_byte_a", 32'(mem[16'h0300]), 32'(first_byte(16'h1357)));
    checkOutput("abort_byte_a1", 32'(mem[16'h0301]), 32'h0);

    repeat (4) @(posedge Clock);
    checkOutput("access_queue_drained", 32'(access_q.size()), 32'h0);
    checkOutput("done_queue_drained", 32'(done_q.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
